dbg_snapshot_streamer: RTL and testbench
========================================

# dbg_snapshot_streamer

Captures a snapshot of the CPU core's internal state and streams it, one 16-bit word at a time, into the monitor system's debug PIO inputs (dbg_data, dbg_we, dbg_clock, dbg_end_sq). It uses the monitor's 4-bit dbg_addr output as a per-word acknowledge. The block sits directly upstream of the monitor, between the CPU core and the monitor's Nios-side debug port. Firmware polls the PIO, so the handshake is fully acknowledged and tolerates arbitrary software latency.

## Interface
- NWORDS, default 12: words per snapshot; legal range 1..15.
- TIMEOUT, default 50_000_000: acknowledge watchdog, in clk cycles. Used only when the watchdog is compiled in.
- clk  in  1  system clock, shared with the monitor.
- reset  in  1  asynchronous, active-high reset.
- snap_req  in  1  single-cycle request; take a snapshot now.
- snap_bus  in  16*NWORDS  CPU state; word i is bits [16*i+15:16*i].
- dbg_addr  in  4  acknowledge code written by monitor firmware.
- dbg_data  out  16  word currently presented.
- dbg_we  out  1  high while a valid word is presented.
- dbg_clock  out  1  toggles once per newly presented word.
- dbg_end_sq  out  1  high once the sequence is complete or aborted.
- busy  out  1  high in every state except IDLE.
- timeout_flag  out  1  sticky; set when the watchdog aborts a sequence.

## Operation
- States: IDLE, CAPTURE, PRESENT, WAIT_ACK, DONE.
- IDLE to CAPTURE: on snap_req=1.
- CAPTURE:
  - latches the whole snap_bus into an internal NWORDS x 16 buffer in one cycle;
  - sets idx=0;
  - goes to PRESENT.
- PRESENT (one cycle):
  - dbg_data <= buf[idx];
  - dbg_we <= 1;
  - dbg_clock <= ~dbg_clock;
  - goes to WAIT_ACK.
- Acknowledge codes:
  - word idx is acknowledged by dbg_addr == idx+1 (values 1..NWORDS);
  - the end of the sequence is acknowledged by dbg_addr == 0.
  - The value 0 left over from the previous end-ack can therefore never acknowledge word 0.
- Ack filtering: an ack counts only if the matching dbg_addr value is sampled on 2 consecutive clk edges. This guards against multi-bit PIO update skew.
- WAIT_ACK, on a filtered ack:
  - if idx < NWORDS-1: idx++ and go to PRESENT;
  - otherwise: dbg_we <= 0, dbg_end_sq <= 1, go to DONE.
- DONE: holds dbg_end_sq=1 until a filtered dbg_addr == 0, then clears dbg_end_sq and goes to IDLE.
- snap_req outside IDLE is ignored. There is no queuing.
- The buffer is frozen from CAPTURE until the next CAPTURE. Changes on snap_bus mid-sequence have no effect.
- dbg_data holds its last value in IDLE and DONE.
- Reset, including mid-sequence: every output goes to 0 (dbg_data=0, dbg_we=0, dbg_clock=0, dbg_end_sq=0, busy=0, timeout_flag=0), idx=0, state=IDLE. Buffer contents are don't-care.

## Timing
- snap_req high at edge N: CAPTURE occupies cycle N+1, and dbg_data, dbg_we and the dbg_clock toggle are visible after edge N+2.
- Ack latency: a matching dbg_addr first sampled at edge M is accepted at edge M+1. The next word is presented after edge M+2.
- Minimum per-word period: 3 cycles (PRESENT, plus 2-cycle filter).
- dbg_we stays high across consecutive words. Only dbg_data and dbg_clock change between words.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- DBG_SNAP_TIMEOUT_EN defined:
  - a counter runs in WAIT_ACK and DONE and is cleared on every state change;
  - when it reaches TIMEOUT-1: dbg_we <= 0, dbg_end_sq <= 0, timeout_flag <= 1, state <= IDLE.
  - timeout_flag clears only on reset.
- DBG_SNAP_TIMEOUT_EN undefined:
  - no counter is built; WAIT_ACK and DONE wait indefinitely;
  - timeout_flag is tied to 0;
  - TIMEOUT is unused.

## Structure
- Package dbg_snap_pkg holds:
  - the state enum;
  - END_ACK = 4'h0;
  - MAX_WORDS = 15;
  - the word-width constant (16).
- Sub-module dbg_ack_filter: registers dbg_addr and compares it with an expected code. Output ack_ok = current and previous samples both equal the expected code. One instance.
- Top level: FSM, buffer, idx counter, optional watchdog.

## Test plan
- Full sequence, NWORDS=12, snap_bus word i = 16'hA000+i, ack codes 1..12 then 0:
  - dbg_data steps through A000..A00B;
  - dbg_clock toggles 12 times;
  - dbg_end_sq rises after ack 12 and falls after the 0 ack;
  - busy falls on return to IDLE.
- Glitch rejection: while word 3 is presented, dbg_addr=4 for 1 cycle then 2 → no advance; dbg_data stays at A003.
- snap_req pulsed during WAIT_ACK and snap_bus changed → ignored; streamed words still match the original capture.
- Reset asserted asynchronously during word 5 → all outputs 0 immediately; a new snap_req restarts at word 0.
- Stale dbg_addr=0 at the start of a second snapshot → word 0 is not acknowledged until dbg_addr=1.
- With DBG_SNAP_TIMEOUT_EN, TIMEOUT=100, no ack given → 100 cycles after PRESENT: timeout_flag=1, dbg_we=0, state IDLE.

Source files
------------

// File: rtl/dbg_snap_pkg.sv
// -----------------------------------------------------------------------------
// dbg_snap_pkg
// Shared types and constants for the debug snapshot streamer: FSM state
// encoding, word/acknowledge widths, the end-of-sequence acknowledge code
// and the helper that maps a word index to its acknowledge code.
// No ports (package).
// -----------------------------------------------------------------------------
package dbg_snap_pkg;

    localparam int WORD_W    = 16;   // width of one streamed word
    localparam int ADDR_W    = 4;    // width of the monitor acknowledge code
    localparam int MAX_WORDS = 15;   // codes 1..15 acknowledge words, 0 ends

    localparam logic [ADDR_W-1:0] END_ACK = 4'h0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_PRESENT,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    // Word idx is acknowledged by code idx+1 so that a leftover END_ACK (0)
    // can never be mistaken for the acknowledge of word 0.
    function automatic logic [ADDR_W-1:0] word_ack_code(input logic [ADDR_W-1:0] idx);
        return idx + 4'd1;
    endfunction

endpackage

// File: rtl/dbg_snapshot_streamer_if.sv
// -----------------------------------------------------------------------------
// dbg_snapshot_streamer_if
// Debug PIO link between the snapshot streamer (master) and the monitor's
// Nios-side debug port (slave).
//   dbg_data   [15:0] master->slave  word currently presented
//   dbg_we            master->slave  high while a valid word is presented
//   dbg_clock         master->slave  toggles once per newly presented word
//   dbg_end_sq        master->slave  sequence complete (or aborted)
//   dbg_addr   [3:0]  slave->master  acknowledge code written by firmware
// -----------------------------------------------------------------------------
interface dbg_snapshot_streamer_if;
    import dbg_snap_pkg::*;

    logic [WORD_W-1:0] dbg_data;
    logic              dbg_we;
    logic              dbg_clock;
    logic              dbg_end_sq;
    logic [ADDR_W-1:0] dbg_addr;

    modport master (
        output dbg_data,
        output dbg_we,
        output dbg_clock,
        output dbg_end_sq,
        input  dbg_addr
    );

    modport slave (
        input  dbg_data,
        input  dbg_we,
        input  dbg_clock,
        input  dbg_end_sq,
        output dbg_addr
    );

endinterface

// File: rtl/dbg_ack_filter.sv
// -----------------------------------------------------------------------------
// dbg_ack_filter
// Two-sample acknowledge filter. The monitor updates its 4-bit PIO with
// software writes whose bits may settle on different edges, so a code only
// counts once it has been seen on two consecutive clk edges.
//   clk       in       system clock
//   reset     in       asynchronous, active-high reset
//   addr      in  [3:0] raw acknowledge code from the monitor
//   expected  in  [3:0] code that would acknowledge the current step
//   ack_ok    out       current and previous samples both equal expected
// -----------------------------------------------------------------------------
module dbg_ack_filter
    import dbg_snap_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] expected,
    output logic              ack_ok
);

    logic [ADDR_W-1:0] addr_prev;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_prev <= END_ACK;
        end else begin
            addr_prev <= addr;
        end
    end

    // The current sample is the live input as seen at the consuming edge; the
    // previous one is the value captured on the edge before it. ack_ok only
    // feeds next-state logic, so no output of the streamer becomes
    // combinational in dbg_addr.
    assign ack_ok = (addr == expected) && (addr_prev == expected);

endmodule

// File: rtl/dbg_snapshot_streamer.sv
// -----------------------------------------------------------------------------
// dbg_snapshot_streamer
// Captures NWORDS x 16-bit words of CPU state on request and streams them one
// at a time into the monitor's debug PIO, waiting for a filtered per-word
// acknowledge from firmware before advancing.
// Parameters:
//   NWORDS   words per snapshot (1..15)
//   TIMEOUT  acknowledge watchdog in clk cycles (watchdog builds only)
// Ports:
//   clk           in   system clock (shared with the monitor)
//   reset         in   asynchronous, active-high reset
//   snap_req      in   single-cycle snapshot request (ignored unless idle)
//   snap_bus      in   CPU state, word i at [16*i+15:16*i]
//   dbg           master modport of dbg_snapshot_streamer_if
//   busy          out  high in every state except IDLE
//   timeout_flag  out  sticky watchdog abort indication
// Build option:
//   DBG_SNAP_TIMEOUT_EN  when defined, a watchdog aborts a sequence that waits
//                        TIMEOUT cycles in WAIT_ACK or DONE; otherwise those
//                        states wait indefinitely and timeout_flag is 0.
// -----------------------------------------------------------------------------
module dbg_snapshot_streamer
    import dbg_snap_pkg::*;
#(
    parameter int NWORDS  = 12,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     snap_req,
    input  logic [WORD_W*NWORDS-1:0] snap_bus,
    dbg_snapshot_streamer_if.master  dbg,
    output logic                     busy,
    output logic                     timeout_flag
);

    if (NWORDS < 1 || NWORDS > MAX_WORDS) begin : g_bad_nwords
        $error("dbg_snapshot_streamer: NWORDS must be within 1..15");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("dbg_snapshot_streamer: TIMEOUT must be at least 2");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NWORDS - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic [WORD_W-1:0] data_q, data_next;
    logic              we_q, we_next;
    logic              clock_q, clock_next;
    logic              end_q, end_next;
    logic              capture_en;

    logic [ADDR_W-1:0] ack_code;
    logic              ack_ok;
    logic              timeout_hit;
    logic              abort;

    logic [WORD_W-1:0] snap_buf [NWORDS];

    // ------------------------------------------------------------------
    // Acknowledge filter: DONE waits for the end code, WAIT_ACK for idx+1.
    // ------------------------------------------------------------------
    assign ack_code = (state == ST_DONE) ? END_ACK : word_ack_code(idx);

    dbg_ack_filter u_ack_filter (
        .clk      (clk),
        .reset    (reset),
        .addr     (dbg.dbg_addr),
        .expected (ack_code),
        .ack_ok   (ack_ok)
    );

    // An acknowledge landing on the same edge as the watchdog wins.
    assign abort = timeout_hit & ~ack_ok;

    // ------------------------------------------------------------------
    // Next-state and next-output logic.
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets its default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        data_next  = data_q;
        we_next    = we_q;
        clock_next = clock_q;
        end_next   = end_q;
        capture_en = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (snap_req) begin
                    state_next = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                capture_en = 1'b1;
                idx_next   = '0;
                state_next = ST_PRESENT;
            end

            ST_PRESENT: begin
                data_next  = snap_buf[idx];
                we_next    = 1'b1;
                clock_next = ~clock_q;
                state_next = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                if (ack_ok) begin
                    if (idx != LAST_IDX) begin
                        idx_next   = idx + 4'd1;
                        state_next = ST_PRESENT;
                    end else begin
                        we_next    = 1'b0;
                        end_next   = 1'b1;
                        state_next = ST_DONE;
                    end
                end else if (abort) begin
                    we_next    = 1'b0;
                    end_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end

            ST_DONE: begin
                if (ack_ok) begin
                    end_next   = 1'b0;
                    state_next = ST_IDLE;
                end else if (abort) begin
                    we_next    = 1'b0;
                    end_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. busy is derived from the next state so it
    // is registered yet still equals (state != IDLE) every cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            clock_q <= 1'b0;
            end_q   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            data_q  <= data_next;
            we_q    <= we_next;
            clock_q <= clock_next;
            end_q   <= end_next;
            busy    <= (state_next != ST_IDLE);
        end
    end

    // NOTE: the snapshot buffer has no reset; it is always written by CAPTURE
    // before PRESENT reads it, and leaving it unreset lets it map to plain
    // flops or RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (capture_en) begin
            for (int i = 0; i < NWORDS; i++) begin
                snap_buf[i] <= snap_bus[i*WORD_W +: WORD_W];
            end
        end
    end

    assign dbg.dbg_data   = data_q;
    assign dbg.dbg_we     = we_q;
    assign dbg.dbg_clock  = clock_q;
    assign dbg.dbg_end_sq = end_q;

    // ------------------------------------------------------------------
    // Optional acknowledge watchdog.
    // ------------------------------------------------------------------
`ifdef DBG_SNAP_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wd_cnt;
    logic             flag_q;
    logic             waiting;

    assign waiting = (state == ST_WAIT_ACK) || (state == ST_DONE);

    // Restarts on every state change, so each word and the final DONE wait
    // each get a full TIMEOUT window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state_next != state) begin
            wd_cnt <= '0;
        end else if (waiting) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign timeout_hit = waiting && (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q <= 1'b0;
        end else if (abort) begin
            flag_q <= 1'b1;
        end
    end

    assign timeout_flag = flag_q;
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_dbg_snapshot_streamer.sv
// -----------------------------------------------------------------------------
// tb_dbg_snapshot_streamer
// Self-checking bench for dbg_snapshot_streamer. A scoreboard queue receives
// the expected words whenever a snapshot is requested; a monitor pops and
// compares one entry each time dbg_clock toggles. The main thread plays the
// role of the monitor firmware driving dbg_addr.
// -----------------------------------------------------------------------------
module tb_dbg_snapshot_streamer;
    import dbg_snap_pkg::*;

    localparam int NW = 12;
    localparam int TO = 100;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 snap_req;
    logic [WORD_W*NW-1:0] snap_bus;
    logic                 busy;
    logic                 timeout_flag;

    dbg_snapshot_streamer_if dbg ();

    dbg_snapshot_streamer #(
        .NWORDS  (NW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .snap_req     (snap_req),
        .snap_bus     (snap_bus),
        .dbg          (dbg),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [WORD_W-1:0] sb_q [$];
    int                present_cnt = 0;
    logic              clk_seen    = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            clk_seen = 1'b0;
        end else if (dbg.dbg_clock !== clk_seen) begin
            clk_seen = dbg.dbg_clock;
            present_cnt++;
            if (sb_q.size() == 0) begin
                check("sb_underflow", sb_q.size(), 1);
            end else begin
                check("word", dbg.dbg_data, sb_q.pop_front());
            end
            check("we_on_word", dbg.dbg_we, 1);
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_snap(input logic [WORD_W-1:0] base);
        for (int i = 0; i < NW; i++) begin
            snap_bus[i*WORD_W +: WORD_W] = base + WORD_W'(i);
            sb_q.push_back(base + WORD_W'(i));
        end
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    task automatic wait_present(input int target);
        int k = 0;
        while (present_cnt < target && k < 50) begin
            tick();
            k++;
        end
        check("present_wait", 32'(present_cnt >= target), 1);
    endtask

    // Streams words from start_word to the end, then performs the end handshake.
    task automatic run_rest(input int base_cnt, input int start_word);
        int k;
        for (int w = start_word; w < NW; w++) begin
            wait_present(base_cnt + w + 1);
            dbg.dbg_addr = 4'(w + 1);
        end
        k = 0;
        while (!dbg.dbg_end_sq && k < 20) begin
            tick();
            k++;
        end
        check("end_sq_rise", dbg.dbg_end_sq, 1);
        check("we_done", dbg.dbg_we, 0);
        check("busy_done", busy, 1);
        dbg.dbg_addr = END_ACK;
        k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        check("end_sq_fall", dbg.dbg_end_sq, 0);
        check("busy_idle", busy, 0);
        check("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int               k;
        int               base_cnt;
        logic             prev_clk;

        reset        = 1'b1;
        snap_req     = 1'b0;
        snap_bus     = '0;
        dbg.dbg_addr = END_ACK;
        repeat (3) tick();

        check("rst_data", dbg.dbg_data, 0);
        check("rst_we", dbg.dbg_we, 0);
        check("rst_clock", dbg.dbg_clock, 0);
        check("rst_end_sq", dbg.dbg_end_sq, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_flag", timeout_flag, 0);
        reset = 1'b0;
        tick();

        // ---- full sequence with glitch and ignored request ----
        do_snap(16'hA000);                 // snap_req sampled at edge N
        check("busy_capture", busy, 1);
        check("we_capture", dbg.dbg_we, 0);
        tick();                            // after N+1: PRESENT not yet visible
        check("we_n1", dbg.dbg_we, 0);
        tick();                            // after N+2: word 0 visible
        check("we_n2", dbg.dbg_we, 1);
        check("clock_n2", dbg.dbg_clock, 1);
        check("data_n2", dbg.dbg_data, 16'hA000);
        wait_present(1);

        // ack word 0 and measure the latency to word 1
        prev_clk     = dbg.dbg_clock;
        dbg.dbg_addr = 4'd1;
        k = 0;
        do begin
            tick();
            k++;
            if (dbg.dbg_clock == prev_clk) check("we_hold", dbg.dbg_we, 1);
        end while (dbg.dbg_clock == prev_clk && k < 10);
        check("ack_latency", k, 3);

        for (int w = 1; w < NW; w++) begin
            wait_present(w + 1);
            if (w == 3) begin
                dbg.dbg_addr = 4'd4;       // one-cycle glitch of the right code
                tick();
                dbg.dbg_addr = 4'd2;
                repeat (6) tick();
                check("glitch_no_adv", present_cnt, 4);
                check("glitch_data", dbg.dbg_data, 16'hA003);
            end
            if (w == 6) begin
                for (int i = 0; i < NW; i++) snap_bus[i*WORD_W +: WORD_W] = 16'hFFFF;
                snap_req = 1'b1;
                tick();
                snap_req = 1'b0;
                repeat (3) tick();
                check("req_ignored_busy", busy, 1);
                check("req_ignored_cnt", present_cnt, 7);
            end
            dbg.dbg_addr = 4'(w + 1);
        end
        run_rest(0, NW);
        check("toggles", present_cnt, NW);
        check("data_hold_idle", dbg.dbg_data, 16'hA00B);

        // ---- stale end-ack must not acknowledge word 0; reset during word 5 ----
        base_cnt = present_cnt;
        do_snap(16'hB000);
        wait_present(base_cnt + 1);
        repeat (8) tick();
        check("stale_no_adv", present_cnt, base_cnt + 1);
        check("stale_data", dbg.dbg_data, 16'hB000);
        dbg.dbg_addr = 4'd1;
        for (int w = 1; w <= 5; w++) begin
            wait_present(base_cnt + w + 1);
            if (w < 5) dbg.dbg_addr = 4'(w + 1);
        end
        check("word5_data", dbg.dbg_data, 16'hB005);
        repeat (2) tick();
        #2;
        reset = 1'b1;                      // asynchronous, mid-cycle
        #1;
        check("arst_data", dbg.dbg_data, 0);
        check("arst_we", dbg.dbg_we, 0);
        check("arst_clock", dbg.dbg_clock, 0);
        check("arst_end_sq", dbg.dbg_end_sq, 0);
        check("arst_busy", busy, 0);
        check("arst_timeout_flag", timeout_flag, 0);
        sb_q.delete();
        dbg.dbg_addr = END_ACK;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // ---- restart from word 0 after reset ----
        base_cnt = present_cnt;
        do_snap(16'hC000);
        run_rest(base_cnt, 0);
        check("restart_toggles", present_cnt - base_cnt, NW);

`ifdef DBG_SNAP_TIMEOUT_EN
        // ---- watchdog abort with no acknowledge ----
        do_snap(16'hD000);
        prev_clk = dbg.dbg_clock;
        k = 0;
        while (dbg.dbg_clock == prev_clk && k < 10) begin
            tick();
            k++;
        end
        check("to_present", 32'(dbg.dbg_clock != prev_clk), 1);
        k = 0;
        while (busy && k < 2 * TO) begin
            tick();
            k++;
        end
        check("to_cycles", k, TO);
        check("to_flag", timeout_flag, 1);
        check("to_we", dbg.dbg_we, 0);
        check("to_end_sq", dbg.dbg_end_sq, 0);
        check("to_busy", busy, 0);
        sb_q.delete();
        repeat (3) tick();
        check("to_flag_sticky", timeout_flag, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
